// File: rtl/fetch_branch_ctrl.sv
// rtl/fetch_branch_ctrl.sv - fetch-side branch controller closing the loop around the PC
// Resolves conditional branches from ROM data and squashes the two wrong-path slots.
module fetch_branch_ctrl #(
    parameter int          AW        = 16,
    parameter int          IW        = 16,
    parameter logic [3:0]  BR_OPCODE = 4'hC
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic [AW-1:0] i_pc_addr,
    input  logic [IW-1:0] i_instr_in,
    input  logic          i_flag_z,
    input  logic          i_flag_c,
    input  logic          i_flag_n,
    output logic [AW-1:0] o_branch_addr,
    output logic          o_sel_next,
    output logic [IW-1:0] o_instr_out,
    output logic          o_instr_valid
);

    typedef enum logic [1:0] {
        ST_START  = 2'd0,
        ST_RUN    = 2'd1,
        ST_FLUSH1 = 2'd2,
        ST_FLUSH2 = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW-1:0] r_pc_d;
    logic [AW-1:0] r_branch_addr;
    logic [AW-1:0] w_branch_addr_nxt;
    logic          r_sel_next;
    logic          w_sel_next_nxt;
    logic [IW-1:0] r_instr_out;
    logic [IW-1:0] w_instr_out_nxt;
    logic          r_instr_valid;
    logic          w_instr_valid_nxt;

    logic          w_is_branch;
    logic [3:0]    w_cond;
    logic          w_taken;
    logic [AW-1:0] w_disp_sext;
    logic [AW-1:0] w_target;

    assign w_is_branch = (i_instr_in[15:12] == BR_OPCODE);
    assign w_cond      = i_instr_in[11:8];
    assign w_disp_sext = {{(AW-8){i_instr_in[7]}}, i_instr_in[7:0]};
    // instr_in is the word fetched at pc_d, so the branch is relative to pc_d
    assign w_target    = r_pc_d + w_disp_sext;

    always_comb begin
        w_taken = 1'b0;
        case (w_cond)
            4'h0:    w_taken = i_flag_z;
            4'h1:    w_taken = !i_flag_z;
            4'h2:    w_taken = i_flag_c;
            4'h3:    w_taken = !i_flag_c;
            4'h4:    w_taken = i_flag_n;
            4'h5:    w_taken = !i_flag_n;
            4'hE:    w_taken = 1'b1;
            default: w_taken = 1'b0;
        endcase
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_branch_addr_nxt = r_branch_addr;
        w_sel_next_nxt    = 1'b0;
        w_instr_out_nxt   = r_instr_out;
        w_instr_valid_nxt = 1'b0;
        case (r_state)
            ST_START: begin
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                w_instr_out_nxt   = i_instr_in;
                w_instr_valid_nxt = 1'b1;
                if (w_is_branch && w_taken) begin
                    w_branch_addr_nxt = w_target;
                    w_sel_next_nxt    = 1'b1;
                    w_state_nxt       = ST_FLUSH1;
                end
            end
            ST_FLUSH1: begin
                w_state_nxt = ST_FLUSH2;
            end
            ST_FLUSH2: begin
                w_state_nxt = ST_RUN;
            end
            default: begin
                w_state_nxt = ST_START;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= ST_START;
            r_pc_d        <= '0;
            r_branch_addr <= '0;
            r_sel_next    <= 1'b0;
            r_instr_out   <= '0;
            r_instr_valid <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc_d        <= i_pc_addr;
            r_branch_addr <= w_branch_addr_nxt;
            r_sel_next    <= w_sel_next_nxt;
            r_instr_out   <= w_instr_out_nxt;
            r_instr_valid <= w_instr_valid_nxt;
        end
    end

    assign o_branch_addr = r_branch_addr;
    assign o_sel_next    = r_sel_next;
    assign o_instr_out   = r_instr_out;
    assign o_instr_valid = r_instr_valid;

endmodule

// File: tb/tb_fetch_branch_ctrl.sv
// tb/tb_fetch_branch_ctrl.sv - closed-loop PC/ROM bench with a slot-counting reference model
// Directed ROM images pin literal branch targets; a random image exercises the model.
module tb_fetch_branch_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] pc_addr = 16'h0;
    logic [15:0] instr_in = 16'h0;
    logic        fz = 1'b0;
    logic        fc = 1'b0;
    logic        fn = 1'b0;
    logic [15:0] o_branch_addr;
    logic        o_sel_next;
    logic [15:0] o_instr_out;
    logic        o_instr_valid;

    always #5 clk = ~clk;

    fetch_branch_ctrl dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_pc_addr     (pc_addr),
        .i_instr_in    (instr_in),
        .i_flag_z      (fz),
        .i_flag_c      (fc),
        .i_flag_n      (fn),
        .o_branch_addr (o_branch_addr),
        .o_sel_next    (o_sel_next),
        .o_instr_out   (o_instr_out),
        .o_instr_valid (o_instr_valid)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] rom [0:65535];
    logic [15:0] inst_a = 16'hFFFF;
    int          visits20 = 0;
    bit          phase_a = 0;

    // reference model: number of upcoming slots still to be discarded
    int          skip = 1;
    logic [15:0] e_addr = 16'h0;
    logic [15:0] e_out = 16'h0;
    logic        e_sel = 1'b0;
    logic        e_valid = 1'b0;
    logic        prev_sel = 1'b0;

    logic [15:0] vstream [$];
    logic [15:0] bstream [$];
    logic        vhist   [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic cond_true(input logic [3:0] c, input logic z, input logic cy, input logic n);
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cy;
            4'h3: return !cy;
            4'h4: return n;
            4'h5: return !n;
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_edge();
        logic [15:0] disp;
        if (reset) begin
            e_addr = 16'h0; e_out = 16'h0; e_sel = 1'b0; e_valid = 1'b0; skip = 1;
        end else if (skip > 0) begin
            e_valid = 1'b0; e_sel = 1'b0; skip--;
        end else begin
            e_out = instr_in; e_valid = 1'b1; e_sel = 1'b0;
            if (instr_in[15:12] == 4'hC && cond_true(instr_in[11:8], fz, fc, fn)) begin
                disp   = {{8{instr_in[7]}}, instr_in[7:0]};
                e_addr = inst_a + disp;
                e_sel  = 1'b1;
                skip   = 2;
            end
        end
    endtask

    task automatic step(input logic r);
        logic        s;
        logic [15:0] b;
        logic [15:0] a_old;
        if (phase_a) fz = (inst_a == 16'h0020) && (visits20 == 2);
        reset = r;
        model_edge();
        s = o_sel_next;
        b = o_branch_addr;
        @(posedge clk);
        #1;
        a_old    = pc_addr;
        instr_in = rom[a_old];
        inst_a   = a_old;
        if (a_old == 16'h0020) visits20++;
        pc_addr  = r ? 16'h0 : (s ? b : a_old + 16'd1);
        @(negedge clk);
        chk("branch_addr", {16'h0, o_branch_addr}, {16'h0, e_addr});
        chk("sel_next", {31'h0, o_sel_next}, {31'h0, e_sel});
        chk("instr_out", {16'h0, o_instr_out}, {16'h0, e_out});
        chk("instr_valid", {31'h0, o_instr_valid}, {31'h0, e_valid});
        chk("sel_back_to_back", {31'h0, s & o_sel_next}, 32'h0);
        prev_sel = o_sel_next;
        vhist.push_back(o_instr_valid);
        if (o_instr_valid) vstream.push_back(o_instr_out);
        if (o_sel_next) bstream.push_back(o_branch_addr);
    endtask

    task automatic fill_seq();
        for (int a = 0; a < 65536; a++) rom[a] = {4'h0, a[11:0]};
    endtask

    task automatic clear_hist();
        vstream.delete(); bstream.delete(); vhist.delete(); visits20 = 0;
    endtask

    function automatic logic [15:0] vs(input int i);
        return (vstream.size() > i) ? vstream[i] : 16'hDEAD;
    endfunction

    function automatic logic [15:0] bs(input int i);
        return (bstream.size() > i) ? bstream[i] : 16'hDEAD;
    endfunction

    initial begin
        logic [31:0] rnd;
        int          k;

        // Directed: sequential NOPs, AL +5, EQ -4 with Z=0 then Z=1, back-to-back AL
        fill_seq();
        rom[16'h0010] = 16'hCE05;
        rom[16'h0020] = 16'hC0FC;
        rom[16'h0030] = 16'hCE10;
        rom[16'h0031] = 16'hCE10;
        rom[16'h0040] = 16'hCEE0;
        phase_a = 1;
        @(negedge clk);
        clear_hist();
        step(1'b1);
        for (int i = 0; i < 90; i++) step(1'b0);
        chk("reset_valid", {31'h0, vhist[0]}, 32'h0);
        chk("start_squash", {31'h0, vhist[1]}, 32'h0);
        chk("first_valid", {31'h0, vhist[2]}, 32'h1);
        chk("first_word", {16'h0, vs(0)}, 32'h0000);
        chk("word_000f", {16'h0, vs(15)}, 32'h000F);
        chk("al_branch_fwd", {16'h0, vs(16)}, 32'hCE05);
        chk("al_target_word", {16'h0, vs(17)}, 32'h0015);
        chk("eq_not_taken_fwd", {16'h0, vs(28)}, 32'hC0FC);
        chk("eq_fallthrough", {16'h0, vs(29)}, 32'h0021);
        chk("b2b_first", {16'h0, vs(44)}, 32'hCE10);
        chk("b2b_second_squashed", {16'h0, vs(45)}, 32'hCEE0);
        chk("eq_taken_fwd", {16'h0, vs(46)}, 32'hC0FC);
        chk("eq_target_word", {16'h0, vs(47)}, 32'h001C);
        chk("br0_addr", {16'h0, bs(0)}, 32'h0015);
        chk("br1_addr", {16'h0, bs(1)}, 32'h0040);
        chk("br2_addr", {16'h0, bs(2)}, 32'h0020);
        chk("br3_addr", {16'h0, bs(3)}, 32'h001C);

        // Directed: address wrap in both directions
        phase_a = 0;
        fz = 1'b0;
        fill_seq();
        rom[16'h0000] = 16'hCEFE;
        rom[16'hFFFE] = 16'hCE04;
        rom[16'h0002] = 16'hCEFF;
        rom[16'h0001] = 16'hCE80;
        clear_hist();
        step(1'b1);
        for (int i = 0; i < 20; i++) step(1'b0);
        chk("wrap_br0", {16'h0, bs(0)}, 32'hFFFE);
        chk("wrap_br1", {16'h0, bs(1)}, 32'h0002);
        chk("wrap_br2", {16'h0, bs(2)}, 32'h0001);
        chk("wrap_br3", {16'h0, bs(3)}, 32'hFF81);
        chk("wrap_v1", {16'h0, vs(1)}, 32'hCE04);
        chk("wrap_v3", {16'h0, vs(3)}, 32'hCE80);
        chk("wrap_v4", {16'h0, vs(4)}, 32'h0F81);

        // Directed: reset while in FLUSH1
        fill_seq();
        rom[16'h0010] = 16'hCE05;
        clear_hist();
        step(1'b1);
        k = 0;
        while (!o_sel_next && k < 100) begin
            step(1'b0);
            k++;
        end
        chk("flush_reached", {31'h0, o_sel_next}, 32'h1);
        step(1'b1);
        chk("rst_flush_sel", {31'h0, o_sel_next}, 32'h0);
        chk("rst_flush_addr", {16'h0, o_branch_addr}, 32'h0);
        chk("rst_flush_out", {16'h0, o_instr_out}, 32'h0);
        chk("rst_flush_valid", {31'h0, o_instr_valid}, 32'h0);
        step(1'b0);
        chk("rst_start_valid", {31'h0, o_instr_valid}, 32'h0);
        chk("rst_no_resend", {31'h0, o_sel_next}, 32'h0);
        step(1'b0);
        chk("rst_restart_valid", {31'h0, o_instr_valid}, 32'h1);
        chk("rst_restart_word", {16'h0, o_instr_out}, 32'h0000);

        // Random ROM image, random flags, occasional reset
        for (int a = 0; a < 65536; a++) begin
            rnd = $urandom();
            if (rnd[31:30] == 2'b00) rom[a] = {4'hC, rnd[11:0]};
            else if (rnd[15:12] == 4'hC) rom[a] = {4'h3, rnd[11:0]};
            else rom[a] = rnd[15:0];
        end
        clear_hist();
        step(1'b1);
        for (int i = 0; i < 3000; i++) begin
            rnd = $urandom();
            fz = rnd[0];
            fc = rnd[1];
            fn = rnd[2];
            step(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
        end
        chk("random_branches_seen", {31'h0, bstream.size() > 20}, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
